// File: rtl/trade_order_ctrl.sv
// Order sequencer: turns qualified buy/sell pulses into single valid/ready orders,
// enforcing a signed position limit, post-fill cooldown and unanswered-order timeout.
module trade_order_ctrl #(
  parameter int ORDER_QTY       = 1,
  parameter int QTY_WIDTH       = 8,
  parameter int POS_WIDTH       = 16,
  parameter int MAX_POSITION    = 10,
  parameter int COOLDOWN_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 16,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        data_valid_z,
  input  logic                        buy_signal,
  input  logic                        sell_signal,
  input  logic                        order_ready,
  output logic                        order_valid,
  output logic                        order_side,
  output logic [QTY_WIDTH-1:0]        order_qty,
  output logic signed [POS_WIDTH-1:0] position,
  output logic [CNT_WIDTH-1:0]        drop_count,
  output logic [CNT_WIDTH-1:0]        timeout_count,
  output logic                        timeout_pulse,
  output logic                        busy
);

  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CD_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, COOLDOWN} state_t;

  state_t          state_reg;
  logic [TO_W-1:0] wait_reg;
  logic [CD_W-1:0] cd_reg;

  logic sig_event;
  logic sig_seen;
  logic accept;
  logic drop_evt;
  logic limit_ok;

  // One extra bit of headroom so the limit test can never wrap.
  logic signed [POS_WIDTH:0] pos_ext;
  logic signed [POS_WIDTH:0] qty_ext;
  logic signed [POS_WIDTH:0] lim_ext;
  logic signed [POS_WIDTH:0] pos_buy;
  logic signed [POS_WIDTH:0] pos_sell;

  assign pos_ext  = {position[POS_WIDTH-1], position};
  assign qty_ext  = (POS_WIDTH+1)'(ORDER_QTY);
  assign lim_ext  = (POS_WIDTH+1)'(MAX_POSITION);
  assign pos_buy  = pos_ext + qty_ext;
  assign pos_sell = pos_ext - qty_ext;
  assign limit_ok = buy_signal ? (pos_buy <= lim_ext) : (pos_sell >= -lim_ext);

  assign sig_event = data_valid_z && (buy_signal ^ sell_signal);
  assign sig_seen  = data_valid_z && (buy_signal || sell_signal);
  assign accept    = (state_reg == IDLE) && sig_event && enable && limit_ok;
  // Any qualified signal that does not become an order is a drop, conflicts included.
  assign drop_evt  = sig_seen && !accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      wait_reg      <= '0;
      cd_reg        <= '0;
      order_valid   <= 1'b0;
      order_side    <= 1'b0;
      order_qty     <= '0;
      position      <= '0;
      drop_count    <= '0;
      timeout_count <= '0;
      timeout_pulse <= 1'b0;
      busy          <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      if (drop_evt && (drop_count != '1))
        drop_count <= drop_count + CNT_WIDTH'(1);

      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg   <= ISSUE;
            busy        <= 1'b1;
            order_valid <= 1'b1;
            order_side  <= buy_signal;
            order_qty   <= QTY_WIDTH'(ORDER_QTY);
            wait_reg    <= '0;
          end
        end

        ISSUE: begin
          if (order_ready) begin
            position    <= order_side ? pos_buy[POS_WIDTH-1:0] : pos_sell[POS_WIDTH-1:0];
            order_valid <= 1'b0;
            order_qty   <= '0;
            cd_reg      <= '0;
            if (COOLDOWN_CYCLES == 0) begin
              state_reg <= IDLE;
              busy      <= 1'b0;
            end else begin
              state_reg <= COOLDOWN;
            end
          end else if (wait_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
            // Last permitted cycle passed with no handshake: cancel the order.
            state_reg     <= IDLE;
            busy          <= 1'b0;
            order_valid   <= 1'b0;
            order_qty     <= '0;
            timeout_pulse <= 1'b1;
            if (timeout_count != '1)
              timeout_count <= timeout_count + CNT_WIDTH'(1);
          end else begin
            wait_reg <= wait_reg + TO_W'(1);
          end
        end

        COOLDOWN: begin
          if (cd_reg == CD_W'(COOLDOWN_CYCLES - 1)) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else begin
            cd_reg <= cd_reg + CD_W'(1);
          end
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trade_order_ctrl.sv
// Randomized plus directed bench for trade_order_ctrl; a queue-based scoreboard
// compares every cycle against a behavioural model of the order rules.
module tb_trade_order_ctrl;

  localparam int MAXP = 2;
  localparam int COOL = 4;
  localparam int TOUT = 16;
  localparam int QTY  = 1;
  localparam int SAT2 = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, enable = 1'b0, data_valid_z = 1'b0;
  logic buy_signal = 1'b0, sell_signal = 1'b0, order_ready = 1'b0;

  logic               order_valid, order_side, timeout_pulse, busy;
  logic [7:0]         order_qty;
  logic signed [15:0] position;
  logic [15:0]        drop_count, timeout_count;

  logic               order_valid2, order_side2, timeout_pulse2, busy2;
  logic [7:0]         order_qty2;
  logic signed [15:0] position2;
  logic [2:0]         drop_count2, timeout_count2;

  trade_order_ctrl #(.ORDER_QTY(QTY), .QTY_WIDTH(8), .POS_WIDTH(16), .MAX_POSITION(MAXP),
    .COOLDOWN_CYCLES(COOL), .TIMEOUT_CYCLES(TOUT), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .data_valid_z(data_valid_z),
    .buy_signal(buy_signal), .sell_signal(sell_signal), .order_ready(order_ready),
    .order_valid(order_valid), .order_side(order_side), .order_qty(order_qty),
    .position(position), .drop_count(drop_count), .timeout_count(timeout_count),
    .timeout_pulse(timeout_pulse), .busy(busy));

  // Narrow-counter copy on the same stimulus, to exercise saturation.
  trade_order_ctrl #(.ORDER_QTY(QTY), .QTY_WIDTH(8), .POS_WIDTH(16), .MAX_POSITION(MAXP),
    .COOLDOWN_CYCLES(COOL), .TIMEOUT_CYCLES(TOUT), .CNT_WIDTH(3)) dut_sat (
    .clk(clk), .rst(rst), .enable(enable), .data_valid_z(data_valid_z),
    .buy_signal(buy_signal), .sell_signal(sell_signal), .order_ready(order_ready),
    .order_valid(order_valid2), .order_side(order_side2), .order_qty(order_qty2),
    .position(position2), .drop_count(drop_count2), .timeout_count(timeout_count2),
    .timeout_pulse(timeout_pulse2), .busy(busy2));

  typedef struct {
    bit valid; bit side; int qty; int pos; int drops; int touts; bit pulse; bit busy;
  } exp_t;

  exp_t exp_q[$];
  bit   ord_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model state: order in flight, cycles it has been shown, cooldown cycles remaining.
  int m_pos = 0, m_drops = 0, m_touts = 0, m_shown = 0, m_cool = 0;
  bit m_inflight = 0, m_side = 0, m_pulse = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > SAT2) ? SAT2 : v;
  endfunction

  task automatic model_step(input bit r, en, dv, b, s, rdy);
    bit seen, ev;
    int np;
    exp_t e;
    seen = dv && (b || s);
    ev   = dv && (b != s);
    if (r) begin
      m_pos = 0; m_drops = 0; m_touts = 0; m_shown = 0; m_cool = 0;
      m_inflight = 0; m_side = 0; m_pulse = 0;
    end else begin
      m_pulse = 0;
      if (m_inflight) begin
        if (seen) m_drops++;
        if (rdy) begin
          m_pos += m_side ? QTY : -QTY;
          m_inflight = 0;
          m_cool = COOL;
        end else if (m_shown == TOUT) begin
          m_inflight = 0;
          m_pulse = 1;
          m_touts++;
        end else begin
          m_shown++;
        end
      end else if (m_cool > 0) begin
        if (seen) m_drops++;
        m_cool--;
      end else if (seen) begin
        np = m_pos + (b ? QTY : -QTY);
        if (ev && en && np <= MAXP && np >= -MAXP) begin
          m_inflight = 1; m_side = b; m_shown = 1;
          ord_q.push_back(b);
        end else begin
          m_drops++;
        end
      end
    end
    e.valid = m_inflight; e.side = m_side; e.qty = m_inflight ? QTY : 0;
    e.pos = m_pos; e.drops = m_drops; e.touts = m_touts; e.pulse = m_pulse;
    e.busy = m_inflight || (m_cool > 0);
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit r, en, dv, b, s, rdy);
    @(negedge clk);
    rst = r; enable = en; data_valid_z = dv;
    buy_signal = b; sell_signal = s; order_ready = rdy;
    model_step(r, en, dv, b, s, rdy);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 1, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    repeat (2) cyc(1, 0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    cyc(0, 1, 0, 0, 0, 0);
    @(posedge clk);
    #2;
  endtask

  task automatic order_fill(input bit b, input int waits);
    cyc(0, 1, 1, b, !b, 0);
    repeat (waits) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1);
  endtask

  // Monitor: per-cycle scoreboard plus order-level check on each new order_valid.
  bit prev_valid = 0;
  always @(posedge clk) begin
    exp_t e;
    bit   s;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("order_valid", order_valid, e.valid);
      if (e.valid) check("order_side", order_side, e.side);
      check("order_qty", order_qty, e.qty);
      check("position", position, e.pos);
      check("drop_count", drop_count, e.drops);
      check("timeout_count", timeout_count, e.touts);
      check("timeout_pulse", timeout_pulse, e.pulse);
      check("busy", busy, e.busy);
      check("sat_valid", order_valid2, e.valid);
      if (e.valid) check("sat_side", order_side2, e.side);
      check("sat_qty", order_qty2, e.qty);
      check("sat_position", position2, e.pos);
      check("sat_drop_count", drop_count2, sat(e.drops));
      check("sat_timeout_count", timeout_count2, sat(e.touts));
      check("sat_pulse", timeout_pulse2, e.pulse);
      check("sat_busy", busy2, e.busy);
    end
    if (!prev_valid && order_valid) begin
      if (ord_q.size() == 0) begin
        check("unexpected_order", 1, 0);
      end else begin
        s = ord_q.pop_front();
        check("new_order_side", order_side, s);
        check("new_order_qty", order_qty, QTY);
      end
    end
    prev_valid = order_valid;
  end

  initial begin
    int pct;
    // Basic fill then full cooldown.
    do_reset();
    idle(1);
    order_fill(1, 2);
    idle(5);
    settle();
    check("basic_position", position, 1);
    check("basic_busy", busy, 0);
    check("basic_drops", drop_count, 0);

    // Position limit: two buys reach +2, third buy rejected, sell accepted.
    do_reset();
    order_fill(1, 0); idle(4);
    order_fill(1, 0); idle(4);
    cyc(0, 1, 1, 1, 0, 0);
    idle(1);
    order_fill(0, 0); idle(4);
    settle();
    check("limit_position", position, 1);
    check("limit_drops", drop_count, 1);

    // Timeout after 16 unanswered cycles, then ready on the 16th cycle fills.
    do_reset();
    cyc(0, 1, 1, 1, 0, 0);
    idle(TOUT);
    idle(2);
    settle();
    check("timeout_count", timeout_count, 1);
    check("timeout_position", position, 0);
    check("timeout_valid", order_valid, 0);
    order_fill(1, TOUT - 1);
    idle(5);
    settle();
    check("lastcycle_position", position, 1);
    check("lastcycle_timeouts", timeout_count, 1);

    // Conflict counts, unqualified signal ignored.
    do_reset();
    cyc(0, 1, 1, 1, 1, 0);
    cyc(0, 1, 0, 1, 0, 0);
    settle();
    check("conflict_drops", drop_count, 1);
    check("conflict_valid", order_valid, 0);

    // Drops during ISSUE (3) and COOLDOWN (4); first IDLE event accepted.
    do_reset();
    cyc(0, 1, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 1, 0);
    cyc(0, 1, 1, 0, 1, 0);
    cyc(0, 1, 1, 0, 1, 1);
    repeat (COOL) cyc(0, 1, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 1, 0);
    settle();
    check("busy_drops", drop_count, 7);
    check("busy_reissue_valid", order_valid, 1);
    check("busy_reissue_side", order_side, 0);
    cyc(0, 1, 0, 0, 0, 1);
    idle(5);

    // Reset mid-order, then enable low in IDLE.
    do_reset();
    cyc(0, 1, 1, 1, 0, 0);
    idle(2);
    cyc(1, 1, 0, 0, 0, 0);
    settle();
    check("midreset_valid", order_valid, 0);
    check("midreset_position", position, 0);
    check("midreset_drops", drop_count, 0);
    cyc(0, 0, 1, 1, 0, 0);
    settle();
    check("disabled_drops", drop_count, 1);
    check("disabled_valid", order_valid, 0);

    // Random traffic with varying gateway responsiveness.
    do_reset();
    pct = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 3))
          0: pct = 0;
          1: pct = 10;
          2: pct = 50;
          default: pct = 90;
        endcase
      end
      cyc(($urandom_range(0, 599) == 0), ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, ($urandom_range(0, 99) < pct));
    end

    @(posedge clk);
    #3;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
